ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of words.
REQ-003 The block SHALL have parameter ADDR_W, default 64, meaning address port width in bits.
REQ-004 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 permisao_escrita  input  1  write enable, active-high.
REQ-007 endereco  input  ADDR_W  word index; no byte addressing.
REQ-008 din  input  DATA_W  write data.
REQ-009 dout  output  DATA_W  read data.
REQ-010 addr_err  output  1  high when endereco >= DEPTH.

Function
REQ-011 The storage SHALL be DEPTH words of DATA_W bits each, indexed directly by endereco.
REQ-012 Read SHALL be combinational: dout = mem[endereco] in the same cycle, with no clock latency.
REQ-013 Write SHALL occur on the rising edge of clk when permisao_escrita=1, reset=0 and endereco < DEPTH: mem[endereco] <= din.
REQ-014 Read-during-write: before the edge, dout shows the old word; after the edge, it shows din.
REQ-015 Out-of-range address (endereco >= DEPTH, all ADDR_W bits compared): dout SHALL be 0, writes SHALL be ignored, and addr_err SHALL be 1.
REQ-016 addr_err SHALL be combinational and SHALL depend only on endereco.
REQ-017 The initial contents (time 0, before any reset) SHALL be mem[i] = i, zero-extended to DATA_W, for all i.
REQ-018 din SHALL be irrelevant when permisao_escrita=0, and contents SHALL remain unchanged.

Reset
REQ-019 While reset=1 at a rising edge, every word SHALL be restored to mem[i] = i, and no write SHALL occur even if permisao_escrita=1.
REQ-020 Reset SHALL NOT gate the read path: dout continues to reflect mem[endereco] and shows the restored values after the reset edge.
REQ-021 Reset asserted mid-sequence SHALL discard all earlier writes.

Structure
REQ-022 DATA_W, DEPTH, ADDR_W defaults and the init-value rule SHALL live in a shared package (ram_pkg).
REQ-023 The block SHALL be a single module with no sub-modules.
REQ-024 The storage SHALL be a register array so that init and reset can be implemented.

Verification
REQ-025 Power-up read: reset=0, write enable=0, endereco 0..31 -> dout = 0..31.
REQ-026 Write sweep: endereco i=0..31, din=(i+10)*3, write enable=1, one edge each -> re-read gives 30,33,...,123.
REQ-027 Read-during-write: endereco 5, din 99, write enable=1 -> dout=5 before the edge and 99 after it.
REQ-028 Reset: after the write sweep, reset=1 for one edge with write enable=1, din=7 -> every word reads back i.
REQ-029 Out of range: endereco 32 and endereco 2^63 with write enable=1, din=1 -> dout=0, addr_err=1, and words 0..31 are unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and the power-up/reset word rule for ram.
package ram_pkg;
   localparam int DATA_W_DEF = 64;
   localparam int DEPTH_DEF = 32;
   localparam int ADDR_W_DEF = 64;
   function automatic logic [63:0] init_val(input int i);
      return 64'(i);
   endfunction
endpackage

// File: rtl/ram_if.sv
// ram_if: word-addressed RAM access bus.
interface ram_if import ram_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic permisao_escrita;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic addr_err;
   modport master(output permisao_escrita, endereco, din, input dout, addr_err);
   modport slave(input permisao_escrita, endereco, din, output dout, addr_err);
endinterface

// File: rtl/ram.sv
// ram: register-array RAM, combinational read, synchronous write, reset restores mem[i] = i.
module ram import ram_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic clk,
   input logic reset,
   ram_if.slave bus
);
   localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
   function automatic mem_t init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(init_val(i));
      return m;
   endfunction
   mem_t mem_q = init_mem();
   mem_t mem_d;
   logic in_range;
   logic [IDX_W-1:0] idx;
   // the full address is compared so high bits never alias onto a valid word
   always_comb begin
      in_range = bus.endereco < ADDR_W'(DEPTH);
      idx = bus.endereco[IDX_W-1:0];
      mem_d = mem_q;
      if (bus.permisao_escrita && in_range) mem_d[idx] = bus.din;
      bus.addr_err = !in_range;
      bus.dout = in_range ? mem_q[idx] : '0;
   end
   always_ff @(posedge clk) mem_q <= reset ? init_mem() : mem_d;
endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram against an array reference model.
module tb_ram;
   localparam int DW = 64;
   localparam int D = 32;
   localparam int AW = 64;
   typedef struct {
      logic [DW-1:0] dout;
      logic err;
      string tag;
   } exp_t;
   logic clk = 0;
   logic reset = 0;
   ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
   ram #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut(.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   exp_t q[$];
   exp_t got;
   longint unsigned model [D];
   int checks = 0;
   int errors = 0;
   always @(negedge clk) if (q.size() > 0) begin
      got = q.pop_front();
      checks += 2;
      if (bus.dout !== got.dout) begin
         errors++;
         $display("FAIL %s addr=%0h dout=%0h expected %0h", got.tag, bus.endereco, bus.dout, got.dout);
      end
      if (bus.addr_err !== got.err) begin
         errors++;
         $display("FAIL %s addr=%0h addr_err=%0b expected %0b", got.tag, bus.endereco, bus.addr_err, got.err);
      end
   end
   task automatic step(input string tag, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      reset = r;
      bus.permisao_escrita = w;
      bus.endereco = a;
      bus.din = d;
      e.dout = (a < D) ? model[a[4:0]] : '0;
      e.err = (a >= D);
      e.tag = tag;
      q.push_back(e);
      if (r) for (int i = 0; i < D; i++) model[i] = i;
      else if (w && a < D) model[a[4:0]] = d;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic r, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < D; i++) model[i] = i;
      bus.permisao_escrita = 0;
      bus.endereco = 0;
      bus.din = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < D; i++) step("powerup", 0, 0, i, {$urandom, $urandom});
      step("rdw_before", 0, 1, 5, 99);
      step("rdw_after", 0, 0, 5, 0);
      for (int i = 0; i < D; i++) step("sweep_wr", 0, 1, i, (i + 10) * 3);
      for (int i = 0; i < D; i++) step("sweep_rd", 0, 0, i, 0);
      step("reset_we", 1, 1, 3, 7);
      for (int i = 0; i < D; i++) step("reset_rd", 0, 0, i, 0);
      step("oor_32", 0, 1, 32, 1);
      step("oor_2p63", 0, 1, 64'h8000_0000_0000_0000, 1);
      step("oor_max", 0, 1, '1, 1);
      for (int i = 0; i < D; i++) step("oor_rd", 0, 0, i, 0);
      step("edge31_wr", 0, 1, 31, 64'hdead_beef_cafe_f00d);
      step("edge31_rd", 0, 0, 31, 0);
      repeat (400) begin
         r = ($urandom_range(0, 49) == 0);
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : AW'($urandom_range(0, D - 1));
         d = {$urandom, $urandom};
         step("random", r, w, a, d);
      end
      repeat (4) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
